pipe_adder: RTL and testbench

- Parametrised pipelined add/subtract unit; successor to the single-cycle 64-bit carry adder.
- The W-bit operation is split into STAGES equal segments. The carry ripples one segment per cycle through registered boundaries, giving full throughput at a short critical path.
- Adds a valid/ready handshake with backpressure, a subtract mode and a signed-overflow flag.
- Sits in the arithmetic datapath between operand sequencer and result consumer.

---
 rtl/pipe_adder_pkg.sv | 24 ++
 rtl/adder_segment.sv | 24 ++
 rtl/pipe_adder.sv | 124 ++++++++++++
 tb/tb_pipe_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
//   op_e      : operation select (add / subtract).
//   result_t  : one result beat {s, carry_out, overflow} at the reference width.
//   stages_ok : legality check for the W / STAGES combination.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned RES_W = 64;

  typedef struct packed {
    logic [RES_W-1:0] s;
    logic             carry_out;
    logic             overflow;
  } result_t;

  function automatic bit stages_ok(input int unsigned w, input int unsigned stages);
    return (w >= 2) && (stages >= 1) && (stages <= w) && ((w % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit adder slice with carry in/out.
//   x, y : segment operands
//   cin  : carry into bit 0 of the segment
//   sum  : segment sum
//   cout : carry out of the segment's top bit
module adder_segment #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] total;

  always_comb begin
    total = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, cin};
    sum   = total[SEG-1:0];
    cout  = total[SEG];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined W-bit add/subtract unit. The carry ripples one SEG-bit segment per
// cycle; a single global enable gives valid/ready backpressure.
//   clock, reset_n       : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready   : operand beat handshake
//   a, b, carry_in, sub  : operands; sub=1 computes a + ~b + carry_in
//   out_valid, out_ready : result beat handshake
//   s, carry_out         : result and carry out of bit W-1 (sub: 1 = no borrow)
//   overflow             : two's-complement signed overflow
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned W      = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         carry_out,
  output logic         overflow
);

  localparam int unsigned SEG  = W / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (!stages_ok(W, STAGES)) begin : g_param_check
    $error("pipe_adder: need W >= 2, 1 <= STAGES <= W and W %% STAGES == 0");
  end

  op_e          op;
  logic         en;
  logic [W-1:0] b_eff;

  // Stage k registers: operands (skew), partial sum (deskew), carry, valid.
  logic         valid_q [STAGES];
  logic [W-1:0] a_q     [STAGES];
  logic [W-1:0] b_q     [STAGES];
  logic [W-1:0] s_q     [STAGES];
  logic         c_q     [STAGES];

  // Stage k combinational inputs and next-state values.
  logic [W-1:0]   a_src    [STAGES];
  logic [W-1:0]   b_src    [STAGES];
  logic           c_src    [STAGES];
  logic           load     [STAGES];
  logic [W-1:0]   s_nxt    [STAGES];
  logic [SEG-1:0] seg_sum  [STAGES];
  logic           seg_cout [STAGES];

  assign op       = op_e'(sub);
  assign b_eff    = (op == OP_SUB) ? ~b : b;
  assign en       = !valid_q[LAST] || out_ready;
  assign in_ready = en;

  always_comb begin
    a_src[0] = a;
    b_src[0] = b_eff;
    c_src[0] = carry_in;
    load[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      load[k]  = valid_q[k-1];
    end
  end

  // Kept apart from the source mux so the segment adders do not form an
  // apparent loop through a single block.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_nxt[k] = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k-1];
      s_nxt[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(.SEG(SEG)) u_seg (
      .x    (a_src[k][k*SEG +: SEG]),
      .y    (b_src[k][k*SEG +: SEG]),
      .cin  (c_src[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  // Data registers load only with a valid beat, so the output holds the last
  // result through bubbles and after reset stays at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
    end else if (en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_q[k] <= load[k];
        if (load[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= seg_cout[k];
        end
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign s         = s_q[LAST];
  assign carry_out = c_q[LAST];
  assign overflow  = (a_q[LAST][W-1] == b_q[LAST][W-1]) &&
                     (s_q[LAST][W-1] != a_q[LAST][W-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (W=64, STAGES=4): directed vectors with
// literal expectations plus a queue-based reference model checked every cycle.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int unsigned W = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         carry_out;
  logic         overflow;

  int pass_cnt = 0;
  int check_cnt = 0;

  result_t      exp_q[$];
  logic [W-1:0] out_log[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_s = '0;
  logic         prev_co = 1'b0;
  logic         prev_ov = 1'b0;

  pipe_adder #(.W(64), .STAGES(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Whole-word arithmetic reference.
  function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, input logic sb);
    result_t      r;
    logic [W-1:0] ye;
    logic [W:0]   t;
    ye = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ci};
    r.s         = t[W-1:0];
    r.carry_out = t[W];
    r.overflow  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Compare process: accepted beats enter the model queue, presented beats are
  // checked against its head, stalled outputs must hold.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'b0, out_valid}, 64'd1);
        chk("hold_s", s, prev_s);
        chk("hold_carry", {63'b0, carry_out}, {63'b0, prev_co});
        chk("hold_ovf", {63'b0, overflow}, {63'b0, prev_ov});
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {63'b0, out_valid}, 64'd0);
        end else begin
          chk("res_s", s, exp_q[0].s);
          chk("res_carry", {63'b0, carry_out}, {63'b0, exp_q[0].carry_out});
          chk("res_ovf", {63'b0, overflow}, {63'b0, exp_q[0].overflow});
          if (out_ready) begin
            out_log.push_back(s);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      prev_co    = carry_out;
      prev_ov    = overflow;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, carry_in, sub));
    end
  end

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
    a = av; b = bv; carry_in = ci; sub = sb; in_valid = 1'b1;
  endtask

  // One beat with out_ready held high: result must appear exactly 4 cycles on.
  task automatic latency_case(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic ci, input logic sb, input logic [W-1:0] es,
                              input logic eco, input logic eov);
    @(posedge clock); #1;
    drive(av, bv, ci, sb);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk({name, "_early"}, {63'b0, out_valid}, 64'd0);
    end
    @(negedge clock);
    chk({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({name, "_s"}, s, es);
    chk({name, "_carry"}, {63'b0, carry_out}, {63'b0, eco});
    chk({name, "_ovf"}, {63'b0, overflow}, {63'b0, eov});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result_t r;
    int      w;

    // Pin the model to hand-computed values.
    r = model(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    chk("pin_ripple_s", r.s, 64'd0);
    chk("pin_ripple_carry", {63'b0, r.carry_out}, 64'd1);
    r = model(64'd5, 64'd7, 1'b1, 1'b1);
    chk("pin_sub_s", r.s, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("pin_sub_carry", {63'b0, r.carry_out}, 64'd0);
    r = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    chk("pin_ovf_flag", {63'b0, r.overflow}, 64'd1);

    // Reset state.
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
      chk("post_rst_s", s, 64'd0);
      chk("post_rst_carry", {63'b0, carry_out}, 64'd0);
      chk("post_rst_ovf", {63'b0, overflow}, 64'd0);
      chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    end

    latency_case("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    latency_case("subtract", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    latency_case("overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Streaming with a 3-cycle consumer stall.
    repeat (2) @(posedge clock);
    out_log.delete();
    fork
      begin : drv
        int   i;
        int   guard;
        logic acc;
        i = 1;
        guard = 0;
        while (i <= 8 && guard < 100) begin
          @(posedge clock); #1;
          drive(W'(i), W'(100 * i), 1'b0, 1'b0);
          @(negedge clock);
          acc = in_ready;
          guard++;
          if (acc) i++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
      end
      begin : cons
        int n;
        n = 0;
        @(negedge clock);
        while (!out_valid && n < 30) begin
          @(negedge clock);
          n++;
        end
        chk("stream_first_seen", {63'b0, out_valid}, 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
          chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("stream_drain", W'(exp_q.size()), 64'd0);
    chk("stream_count", W'(out_log.size()), 64'd8);
    for (int i = 0; i < out_log.size() && i < 8; i++)
      chk("stream_value", out_log[i], W'(101 * (i + 1)));

    // Reset with beats in flight.
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      drive(W'(k), W'(k), 1'b0, 1'b0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    chk("midrst_before", {63'b0, out_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_async", {63'b0, out_valid}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clock);
      chk("midrst_quiet", {63'b0, out_valid}, 64'd0);
    end
    latency_case("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("final_drain", W'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
